// File: rtl/m_cp0.sv
// MIPS-style coprocessor 0: SR/Cause/EPC registers, interrupt/exception entry and eret.
// Optional PRId read-back at address 15 when CP0_PRID_EN is defined.
module m_cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hwint,
    input  logic        eret,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc,
    output logic        req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0]  ADDR_PRID = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h2021_B0AA;
`endif

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;

    assign w_int_req = (|(hwint & r_sr_im)) & r_sr_ie & ~r_sr_exl;
    assign w_exc_req = (exccode_in != 5'd0) & ~r_sr_exl;
    assign req       = w_int_req | w_exc_req;
    assign epc       = r_epc;

    assign w_sr    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= '0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
            r_epc       <= '0;
        end else begin
            r_cause_ip <= hwint;
            if (req) begin
                // Handler entry; a delay-slot victim restarts at its branch.
                r_sr_exl    <= 1'b1;
                r_cause_bd  <= bd_in;
                r_cause_exc <= w_int_req ? 5'd0 : exccode_in;
                r_epc       <= (vpc & ~32'd3) - (bd_in ? 32'd4 : 32'd0);
            end else begin
                if (en) begin
                    case (cp0_addr)
                        ADDR_SR: begin
                            r_sr_im  <= cp0_wdata[15:10];
                            r_sr_exl <= cp0_wdata[1];
                            r_sr_ie  <= cp0_wdata[0];
                        end
                        ADDR_EPC: r_epc <= cp0_wdata & ~32'd3;
                        default: ;
                    endcase
                end
                // NOTE: the last non-blocking assignment to r_sr_exl wins, so eret overrides an SR write.
                if (eret) begin
                    r_sr_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = w_sr;
            ADDR_CAUSE: cp0_rdata = w_cause;
            ADDR_EPC:   cp0_rdata = r_epc;
`ifdef CP0_PRID_EN
            ADDR_PRID:  cp0_rdata = PRID_VAL;
`endif
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_m_cp0.sv
// Directed bench for m_cp0: stimulus pushes expected values to a queue, a monitor
// process pops and compares them against the live DUT outputs.
module tb_m_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exccode_in;
    logic [5:0]  hwint;
    logic        eret;
    logic [31:0] cp0_rdata;
    logic [31:0] epc;
    logic        req;

    m_cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exccode_in (exccode_in),
        .hwint      (hwint),
        .eret       (eret),
        .cp0_rdata  (cp0_rdata),
        .epc        (epc),
        .req        (req)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef enum int { SEL_REQ, SEL_RDATA, SEL_EPC } sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    event     ev_sample;
    int       n_vec = 0;
    int       n_err = 0;

`ifdef CP0_PRID_EN
    localparam logic [31:0] EXP_PRID = 32'h2021_B0AA;
`else
    localparam logic [31:0] EXP_PRID = 32'h0;
`endif

    // Monitor: compare every queued expectation against the DUT at the sample point.
    initial begin
        sb_item_t    it;
        logic [31:0] act;
        forever begin
            @(ev_sample);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                case (it.sel)
                    SEL_REQ:   act = {31'd0, req};
                    SEL_RDATA: act = cp0_rdata;
                    default:   act = epc;
                endcase
                n_vec++;
                if (act !== it.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic check(input string name, input sel_e sel, input logic [31:0] exp);
        sb_item_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        sb_q.push_back(it);
        -> ev_sample;
        #1;
    endtask

    task automatic rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
        cp0_addr = addr;
        #1;
        check(name, SEL_RDATA, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        en        = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        tick();
        en = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cp0_addr = '0; cp0_wdata = '0; vpc = '0;
        bd_in = 1'b0; exccode_in = '0; hwint = '0; eret = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd("rst_sr", 5'd12, 32'h0);
        rd("rst_cause", 5'd13, 32'h0);
        rd("rst_epc", 5'd14, 32'h0);
        check("rst_epc_out", SEL_EPC, 32'h0);
        hwint = 6'b000001;
        #1;
        check("rst_req_masked", SEL_REQ, 32'h0);

        // Interrupt entry
        vpc = 32'h0000_3010;
        mtc0(5'd12, 32'h0000_0401);
        rd("int_sr_written", 5'd12, 32'h0000_0401);
        check("int_req", SEL_REQ, 32'h1);
        tick();
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_epc", 5'd14, 32'h0000_3010);
        check("int_epc_out", SEL_EPC, 32'h0000_3010);
        check("int_req_after", SEL_REQ, 32'h0);

        // Nested entry blocked; eret re-enables a pending interrupt
        exccode_in = 5'd12;
        #1;
        check("exl_blocks_exc", SEL_REQ, 32'h0);
        exccode_in = 5'd0;
        do_eret();
        rd("eret_sr", 5'd12, 32'h0000_0401);
        check("eret_pending_req", SEL_REQ, 32'h1);
        vpc = 32'h0000_3040;
        tick();
        check("reentry_epc", SEL_EPC, 32'h0000_3040);
        hwint = 6'b0;
        do_eret();

        // Exception in a delay slot
        mtc0(5'd12, 32'h0000_0001);
        exccode_in = 5'd4; vpc = 32'h0000_3020; bd_in = 1'b1;
        #1;
        check("exc_req", SEL_REQ, 32'h1);
        tick();
        rd("exc_epc", 5'd14, 32'h0000_301C);
        rd("exc_cause", 5'd13, 32'h8000_0010);
        rd("exc_sr", 5'd12, 32'h0000_0003);
        exccode_in = 5'd0; bd_in = 1'b0;
        do_eret();

        // Interrupt beats exception
        mtc0(5'd12, 32'h0000_0401);
        hwint = 6'b000001; exccode_in = 5'd10; vpc = 32'h0000_3050;
        #1;
        check("prio_req", SEL_REQ, 32'h1);
        tick();
        rd("prio_cause", 5'd13, 32'h0000_0400);
        rd("prio_epc", 5'd14, 32'h0000_3050);
        hwint = 6'b0; exccode_in = 5'd0;
        do_eret();

        // req suppresses mtc0; unaligned victim PC is word-aligned
        exccode_in = 5'd8; vpc = 32'h0000_3067;
        en = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0000_3007;
        #1;
        check("sup_req", SEL_REQ, 32'h1);
        tick();
        en = 1'b0;
        rd("sup_epc", 5'd14, 32'h0000_3064);
        exccode_in = 5'd0;
        do_eret();
        mtc0(5'd14, 32'h0000_3007);
        rd("mtc0_epc", 5'd14, 32'h0000_3004);
        check("mtc0_epc_out", SEL_EPC, 32'h0000_3004);

        // Ignored writes, unimplemented reads, field masking, eret vs SR write
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd("cause_ro", 5'd13, 32'h0000_0020);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd("prid", 5'd15, EXP_PRID);
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd("unimpl", 5'd3, 32'h0);
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd("sr_mask", 5'd12, 32'h0000_FC03);
        check("sr_mask_req", SEL_REQ, 32'h0);
        eret = 1'b1;
        mtc0(5'd12, 32'hFFFF_FFFF);
        eret = 1'b0;
        rd("eret_sr_write", 5'd12, 32'h0000_FC01);

        // Reset beats a pending request
        hwint = 6'b000100;
        #1;
        check("pre_rst_req", SEL_REQ, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("rst2_sr", 5'd12, 32'h0);
        rd("rst2_cause", 5'd13, 32'h0);
        rd("rst2_epc", 5'd14, 32'h0);
        check("rst2_req", SEL_REQ, 32'h0);
        tick();
        rd("ip_sample", 5'd13, 32'h0000_1000);
        hwint = 6'b0;

        #20;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/m_cp0.md
M_CP0 -- requirements
Module: m_cp0

Interface
- REQ-001 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
- REQ-003 The block SHALL have port `en`, input, 1 bit: mtc0 write enable.
- REQ-004 The block SHALL have port `cp0_addr`, input, 5 bits: register index for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PRId).
- REQ-005 The block SHALL have port `cp0_wdata`, input, 32 bits: mtc0 write data.
- REQ-006 The block SHALL have port `vpc`, input, 32 bits: PC of the instruction in the M stage (victim PC).
- REQ-007 The block SHALL have port `bd_in`, input, 1 bit: the victim instruction is in a branch delay slot.
- REQ-008 The block SHALL have port `exccode_in`, input, 5 bits: pipeline exception code; 0 means no exception.
- REQ-009 The block SHALL have port `hwint`, input, 6 bits: hardware interrupt lines (timer0, timer1, external, ...).
- REQ-010 The block SHALL have port `eret`, input, 1 bit: eret is in the M stage; it clears EXL.
- REQ-011 The block SHALL have port `cp0_rdata`, output, 32 bits: mfc0 read data (combinational).
- REQ-012 The block SHALL have port `epc`, output, 32 bits: current EPC register, fed to next-PC logic.
- REQ-013 The block SHALL have port `req`, output, 1 bit: combinational request to enter the handler (redirect to 0x0000_4180, flush pipeline).

Function
- REQ-014 The block SHALL implement the SR fields IM = SR[15:10], EXL = SR[1] and IE = SR[0]; all other SR bits SHALL read 0.
- REQ-015 The block SHALL implement the Cause fields BD = Cause[31], IP = Cause[15:10] and ExcCode = Cause[6:2]; all other Cause bits SHALL read 0.
- REQ-016 The block SHALL compute int_req = |(hwint & IM) & IE & !EXL.
- REQ-017 The block SHALL compute exc_req = (exccode_in != 0) & !EXL.
- REQ-018 The block SHALL drive req = int_req | exc_req.
- REQ-019 On a cycle with req=1, the block SHALL update at the clock edge as follows:
  - EXL <= 1.
  - BD <= bd_in.
  - ExcCode <= 0 if int_req, else exccode_in; interrupt has priority.
  - EPC <= {vpc[31:2],2'b00} - (bd_in ? 4 : 0).
- REQ-020 On a req=1 cycle, the block SHALL suppress any mtc0 write (req has priority over en).
- REQ-021 With req=0 and eret=1, the block SHALL clear EXL at the clock edge.
- REQ-022 Simultaneous eret with en=1 and cp0_addr=12 SHALL be resolved as follows: the written SR value is taken, then EXL is forced to 0.
- REQ-023 With req=0 and en=1, the block SHALL write cp0_wdata into the register addressed by cp0_addr, masked to the implemented fields.
  - Writes to addr 13 or 15 SHALL be ignored.
  - EPC writes SHALL be word-aligned (low 2 bits forced to 0).
- REQ-024 The block SHALL sample IP <= hwint on every clock edge regardless of req, en or EXL.
- REQ-025 cp0_rdata SHALL reflect register state before the current edge; the same-cycle write is not forwarded.
- REQ-026 Unimplemented addresses SHALL read 0.
- REQ-027 The block SHALL drive epc = EPC register continuously.
- REQ-028 While EXL=1, req SHALL be 0 for any hwint or exccode_in, so that nested entry is impossible.

Reset
- REQ-029 When reset=1 at a clock edge, the block SHALL clear SR, Cause and EPC to 32'h0.
- REQ-030 After reset, req SHALL be 0 (IE=0, IM=0).
- REQ-031 Reset SHALL take precedence over req, eret and en in the same cycle.
- REQ-032 Reset mid-handler SHALL clear EXL.

Configuration
- REQ-033 With macro CP0_PRID_EN defined, reads of addr 15 SHALL return the constant 32'h2021_B0AA.
- REQ-034 With CP0_PRID_EN undefined, reads of addr 15 SHALL return 0, and no PRId logic SHALL be present.

Verification
- REQ-035 The bench SHALL cover: reset; read addr 12/13/14 -> all 0; hwint=6'b000001 -> req=0.
- REQ-036 The bench SHALL cover: mtc0 SR=32'h0000_0401, hwint[0]=1, vpc=32'h0000_3010, bd_in=0 -> req=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=32'h0000_300C+4=32'h0000_3010, req=0.
- REQ-037 The bench SHALL cover: SR=32'h1, exccode_in=5'd4, vpc=32'h0000_3020, bd_in=1 -> req=1; then EPC=32'h0000_301C, BD=1, ExcCode=4.
- REQ-038 The bench SHALL cover: int_req and exccode_in=10 in the same cycle -> ExcCode=0.
- REQ-039 The bench SHALL cover: EXL=1, exccode_in=12 -> req=0; eret=1 -> EXL=0 next cycle; a pending interrupt then asserts req.
- REQ-040 The bench SHALL cover: en=1, addr=14, wdata=32'h0000_3007 while req=1 -> EPC takes the exception value, not 32'h0000_3004; with req=0 -> EPC=32'h0000_3004; read addr 15 -> 32'h2021_B0AA with CP0_PRID_EN, else 0.
